vga_frame_renderer: RTL

//  Display-side end of the game-state/pixel interface. Generates 640x480@60 VGA timing from clk_100mhz
//  and drives pixel_x/pixel_y to the game core. Samples the returned category/addr/tank_direct/

---
 rtl/vga_frame_renderer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_renderer.sv
// vga_frame_renderer
//   Display end of the game-state/pixel interface. Generates 640x480@60 VGA timing
//   from the 100 MHz clock, one pixel every 4 clk. The current pixel is offered to the
//   game core on pixel_x/pixel_y. The core's answer (category/addr/direction/owner/alive)
//   is sampled mid-pixel. Tank addresses are rotated into the right-facing sprite ROM,
//   and the registered colour and sync are driven to the connector.
//
// Ports
//   clk_100mhz  system clock
//   rst         asynchronous reset, active-high
//   category    0 none, 1 wall, 2 tank, 3 bullet, others none
//   addr        tank pixel index row*SPRITE+col+1 (1..SPRITE*SPRITE)
//   tank_direct 0 left, 1 right, 2 up, 3 down, 4..7 right
//   player_tank tank pixel belongs to the player
//   alive       player alive (selects background colour)
//   rom_data    sprite ROM data, one clk after rom_addr
//   pixel_x     horizontal counter 0..799
//   pixel_y     vertical counter 0..524
//   rom_addr    sprite ROM address 0..SPRITE*SPRITE-1
//   rgb         {r,g,b}, registered; lags pixel_x/pixel_y by 4 clk
//   hsync/vsync active-low sync, registered with rgb
//   frame_tick  1-clk pulse as pixel_y enters the first blanking line
module vga_frame_renderer #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int SPRITE = 30,
  parameter int DATA_W = 12,
  parameter logic [DATA_W-1:0] TRANSPARENT = 12'h000,
  parameter logic [DATA_W-1:0] C_WALL      = 12'h888,
  parameter logic [DATA_W-1:0] C_BULLET    = 12'hFF0,
  parameter logic [DATA_W-1:0] C_BG        = 12'h000,
  parameter logic [DATA_W-1:0] C_DEAD_BG   = 12'h400
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic [3:0]        category,
  input  logic [9:0]        addr,
  input  logic [2:0]        tank_direct,
  input  logic              player_tank,
  input  logic              alive,
  input  logic [DATA_W-1:0] rom_data,
  output logic [9:0]        pixel_x,
  output logic [9:0]        pixel_y,
  output logic [9:0]        rom_addr,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_tick
);

  localparam logic [9:0] X_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] Y_VIS    = 10'(V_VIS);
  localparam logic [9:0] Y_VIS_M1 = 10'(V_VIS - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  localparam logic [9:0] SP_N    = 10'(SPRITE);
  localparam logic [9:0] SP_LAST = 10'(SPRITE - 1);
  localparam logic [9:0] SP_AREA = 10'(SPRITE * SPRITE);

  localparam logic [3:0] CAT_WALL   = 4'd1;
  localparam logic [3:0] CAT_TANK   = 4'd2;
  localparam logic [3:0] CAT_BULLET = 4'd3;

  localparam logic [2:0] DIR_LEFT = 3'd0;
  localparam logic [2:0] DIR_UP   = 3'd2;
  localparam logic [2:0] DIR_DOWN = 3'd3;

  localparam int CW = DATA_W / 3;

  logic [1:0]        ph;
  logic [3:0]        cat_p1;
  logic [9:0]        addr_p1;
  logic [2:0]        dir_p1;
  logic              ply_p1;
  logic              alive_p1;
  logic              vld_p1;
  logic              addr_ok_p1;
  logic [DATA_W-1:0] colour_p2;

  // Rotate a sprite pixel index into the ROM's right-facing layout. The divide and
  // modulo are by a constant, so they reduce to fixed logic that settles in one clk.
  function automatic logic [9:0] remap_addr(input logic [9:0] a_in, input logic [2:0] dir);
    logic [9:0] a;
    logic [9:0] r;
    logic [9:0] c;
    logic [9:0] sr;
    logic [9:0] sc;
    a = a_in - 10'd1;
    r = a / SP_N;
    c = a % SP_N;
    case (dir)
      DIR_LEFT: begin sr = r;           sc = SP_LAST - c; end
      DIR_UP:   begin sr = c;           sc = SP_LAST - r; end
      DIR_DOWN: begin sr = SP_LAST - c; sc = r;           end
      default:  begin sr = r;           sc = c;           end
    endcase
    return sr * SP_N + sc;
  endfunction

  // Enemy tanks reuse the player sprite with red and green swapped.
  function automatic logic [DATA_W-1:0] enemy_tint(input logic [DATA_W-1:0] pix);
    return {pix[2*CW-1:CW], pix[3*CW-1:2*CW], pix[CW-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] pick_colour(
    input logic              vis,
    input logic [3:0]        cat,
    input logic              ok,
    input logic              ply,
    input logic              alv,
    input logic [DATA_W-1:0] pix
  );
    logic [DATA_W-1:0] bg;
    logic [DATA_W-1:0] col;
    bg  = alv ? C_BG : C_DEAD_BG;
    col = bg;
    case (cat)
      CAT_WALL:   col = C_WALL;
      CAT_BULLET: col = C_BULLET;
      CAT_TANK:   if (ok && (pix != TRANSPARENT)) col = ply ? pix : enemy_tint(pix);
      default:    col = bg;
    endcase
    if (!vis) col = '0;
    return col;
  endfunction

  // p0: pixel phase and raster counters
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      ph      <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd3) begin
        if (pixel_x == X_LAST) begin
          pixel_x <= '0;
          pixel_y <= (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
        end else begin
          pixel_x <= pixel_x + 10'd1;
        end
      end
    end
  end

  // p1: game-core answer sampled at the ph1->2 edge
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      cat_p1   <= '0;
      addr_p1  <= '0;
      dir_p1   <= '0;
      ply_p1   <= 1'b0;
      alive_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (ph == 2'd1) begin
      cat_p1   <= category;
      addr_p1  <= addr;
      dir_p1   <= tank_direct;
      ply_p1   <= player_tank;
      alive_p1 <= alive;
      vld_p1   <= (pixel_x < X_VIS) && (pixel_y < Y_VIS);
    end
  end

  assign addr_ok_p1 = (addr_p1 != 10'd0) && (addr_p1 <= SP_AREA);
  assign rom_addr   = addr_ok_p1 ? remap_addr(addr_p1, dir_p1) : 10'd0;

  // p2: ROM data is back during ph3; colour and sync register at the ph3->0 edge
  assign colour_p2 = pick_colour(vld_p1, cat_p1, addr_ok_p1, ply_p1, alive_p1, rom_data);

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      rgb        <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (ph == 2'd3) && (pixel_x == X_LAST) && (pixel_y == Y_VIS_M1);
      if (ph == 2'd3) begin
        rgb   <= colour_p2;
        hsync <= !((pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST));
        vsync <= !((pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST));
      end
    end
  end

endmodule
